// File: rtl/proj1_pkg.sv
// Shared types for the bit-serial operand comparator.
package proj1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
        logic any_match;
    } cmp_result_t;

endpackage

// File: rtl/bit_pair_cell.sv
// Per-bit compare cell: match flag, difference flag and MSB-first gt/lt decision.
module bit_pair_cell (
    input  logic x_bit,
    input  logic y_bit,
    input  logic eq_run,
    output logic m_c,
    output logic diff_c,
    output logic decide_c,
    output logic gt_c,
    output logic lt_c
);

    assign diff_c   = x_bit ^ y_bit;
    assign m_c      = ~diff_c;
    // The first differing bit (while still equal so far) settles the ordering.
    assign decide_c = eq_run & diff_c;
    assign gt_c     = decide_c & x_bit;
    assign lt_c     = decide_c & y_bit;

endmodule

// File: rtl/serial_pair_comparator.sv
// Bit-serial unsigned comparator with match count; consumes one bit-pair per accept, MSB first.
module serial_pair_comparator
    import proj1_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic          x_bit,
    input  logic          y_bit,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          eq,
    output logic          gt,
    output logic          lt,
    output logic          any_match,
    output logic [CW-1:0] match_count
);

    state_t      state_q;
    state_t      state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] mc_q;
    logic [CW-1:0] mc_d;
    cmp_result_t res_q;
    logic        eq_run_q;
    logic        eq_run_d;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        gt_d;
    logic        lt_d;
    logic        any_d;

    logic        accept_c;
    logic        load_c;
    logic        step_c;
    logic        eq_eff_c;
    logic        m_c;
    logic        diff_c;
    logic        decide_c;
    logic        gt_c;
    logic        lt_c;

    assign accept_c = in_valid & in_ready_q;

    // Bit 0 sees a fresh "still equal" history regardless of stale state.
    assign eq_eff_c = load_c | eq_run_q;

    bit_pair_cell u_cell (
        .x_bit    (x_bit),
        .y_bit    (y_bit),
        .eq_run   (eq_eff_c),
        .m_c      (m_c),
        .diff_c   (diff_c),
        .decide_c (decide_c),
        .gt_c     (gt_c),
        .lt_c     (lt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c && in_first) begin
                    load_c  = 1'b1;
                    state_d = (WIDTH == 1) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (accept_c) begin
                    if (in_first) begin
                        load_c = 1'b1;
                    end else begin
                        step_c = 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next accumulator values for the bit currently being accepted.
    always_comb begin
        mc_d     = (load_c ? '0 : mc_q) + CW'(m_c);
        any_d    = (load_c ? 1'b0 : res_q.any_match) | m_c;
        gt_d     = decide_c ? gt_c : (load_c ? 1'b0 : res_q.gt);
        lt_d     = decide_c ? lt_c : (load_c ? 1'b0 : res_q.lt);
        eq_run_d = eq_eff_c & ~diff_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            mc_q        <= '0;
            res_q       <= '0;
            eq_run_q    <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_d != DONE);
            out_valid_q <= (state_d == DONE);
            if (load_c || step_c) begin
                mc_q            <= mc_d;
                res_q.any_match <= any_d;
                res_q.gt        <= gt_d;
                res_q.lt        <= lt_d;
                eq_run_q        <= eq_run_d;
                if (state_d == DONE) begin
                    res_q.eq <= eq_run_d;
                    cnt_q    <= '0;
                end else if (load_c) begin
                    cnt_q    <= CW'(1);
                end else begin
                    cnt_q    <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign eq          = res_q.eq;
    assign gt          = res_q.gt;
    assign lt          = res_q.lt;
    assign any_match   = res_q.any_match;
    assign match_count = mc_q;

endmodule

// File: tb/tb_serial_pair_comparator.sv
// Randomised and directed checks of serial_pair_comparator against a word-level reference model.
module tb_serial_pair_comparator;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_first;
    logic          x_bit;
    logic          y_bit;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          eq;
    logic          gt;
    logic          lt;
    logic          any_match;
    logic [CW-1:0] match_count;

    int total = 0;
    int bad   = 0;

    serial_pair_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_first    (in_first),
        .x_bit       (x_bit),
        .y_bit       (y_bit),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt),
        .any_match   (any_match),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // Reference model: collects whole words, then compares them as integers.
    logic         m_rdy;
    logic         m_pend;
    logic         m_in;
    int           m_n;
    logic [W-1:0] m_x;
    logic [W-1:0] m_y;
    logic         m_eq;
    logic         m_gt;
    logic         m_lt;
    int           m_mc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdy  <= 1'b0;
            m_pend <= 1'b0;
            m_in   <= 1'b0;
            m_n    <= 0;
            m_x    <= '0;
            m_y    <= '0;
            m_eq   <= 1'b0;
            m_gt   <= 1'b0;
            m_lt   <= 1'b0;
            m_mc   <= 0;
        end else begin : upd
            logic         pend;
            logic         inw;
            int           n;
            logic [W-1:0] xs;
            logic [W-1:0] ys;
            pend = m_pend;
            inw  = m_in;
            n    = m_n;
            xs   = m_x;
            ys   = m_y;
            if (pend && out_ready) pend = 1'b0;
            if (in_valid && m_rdy) begin
                if (in_first) begin
                    xs  = W'(x_bit);
                    ys  = W'(y_bit);
                    n   = 1;
                    inw = 1'b1;
                end else if (inw) begin
                    xs = (xs << 1) | W'(x_bit);
                    ys = (ys << 1) | W'(y_bit);
                    n  = n + 1;
                end
            end
            if (inw && n == int'(W)) begin
                pend = 1'b1;
                inw  = 1'b0;
                n    = 0;
                m_eq <= (xs == ys);
                m_gt <= (xs > ys);
                m_lt <= (xs < ys);
                m_mc <= $countones(~(xs ^ ys));
            end
            m_pend <= pend;
            m_in   <= inw;
            m_n    <= n;
            m_x    <= xs;
            m_y    <= ys;
            m_rdy  <= !pend;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: sample after the edge has settled and compare against the model.
    task automatic tick();
        @(posedge clk);
        #2;
        if (rst) begin
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_flags", int'({eq, gt, lt, any_match}), 0);
            chk("rst_match_count", int'(match_count), 0);
        end else begin
            chk("in_ready", int'(in_ready), int'(m_rdy));
            chk("out_valid", int'(out_valid), int'(m_pend));
            if (m_pend) begin
                chk("eq", int'(eq), int'(m_eq));
                chk("gt", int'(gt), int'(m_gt));
                chk("lt", int'(lt), int'(m_lt));
                chk("any_match", int'(any_match), int'(m_mc != 0));
                chk("match_count", int'(match_count), m_mc);
            end else begin
                chk("fields_known", int'($isunknown({eq, gt, lt, any_match, match_count})), 0);
            end
        end
    endtask

    task automatic send_bits(input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input int count, input int gap_at, input int gap_len,
                             output int cyc);
        cyc = 0;
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            in_first = (i == 0);
            x_bit    = xv[W-1-i];
            y_bit    = yv[W-1-i];
            tick();
            cyc++;
            if (i == gap_at) begin
                in_valid = 1'b0;
                in_first = 1'b0;
                repeat (gap_len) begin
                    tick();
                    cyc++;
                end
            end
        end
    endtask

    task automatic send_word(input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input int gap_at, input int gap_len, output int cyc);
        send_bits(xv, yv, int'(W), gap_at, gap_len, cyc);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
    endtask

    task automatic chk_result(input string nm, input int e, input int g, input int l,
                              input int a, input int mc);
        chk({nm, "_eq"}, int'(eq), e);
        chk({nm, "_gt"}, int'(gt), g);
        chk({nm, "_lt"}, int'(lt), l);
        chk({nm, "_any"}, int'(any_match), a);
        chk({nm, "_count"}, int'(match_count), mc);
    endtask

    initial begin
        int cyc;
        int n;
        int words;
        logic [CW-1:0] held_mc;

        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0;
        x_bit = 1'b0; y_bit = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_in_ready", int'(in_ready), 1);

        // Equal operands; latency counts the accept cycle through the first valid cycle.
        send_word(8'hA5, 8'hA5, -1, 0, cyc);
        wait_result(n);
        chk("equal_latency", cyc + n + 1, 9);
        chk_result("equal", 1, 0, 0, 1, 8);
        tick();
        chk("equal_single_cycle", int'(out_valid), 0);

        send_word(8'h0F, 8'hF0, -1, 0, cyc);
        wait_result(n);
        chk_result("complement", 0, 0, 1, 0, 0);
        tick();

        // Three idle cycles after bit 4 delay the result by exactly three cycles.
        send_word(8'h80, 8'h7F, 4, 3, cyc);
        wait_result(n);
        chk("gap_latency", cyc + n + 1, 12);
        chk_result("msb", 0, 1, 0, 0, 0);
        tick();

        // Restart partway through a word; only the second word yields a result.
        send_bits(8'h12, 8'h34, 5, -1, 0, cyc);
        chk("abort_no_result", int'(out_valid), 0);
        send_word(8'h3C, 8'h3D, -1, 0, cyc);
        wait_result(n);
        chk("abort_latency", cyc + n + 1, 9);
        chk_result("abort", 0, 0, 1, 1, 7);
        tick();

        // Backpressure: result held, MSB pulses dropped while out_ready is low.
        out_ready = 1'b0;
        send_word(8'h00, 8'h00, -1, 0, cyc);
        wait_result(n);
        held_mc = match_count;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_first = 1'b1; x_bit = 1'b1; y_bit = 1'b0;
            tick();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_count_stable", int'(match_count), int'(held_mc));
            chk_result("bp", 1, 0, 0, 1, 8);
        end
        in_valid = 1'b0; in_first = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);

        // Asynchronous reset partway through a word.
        send_bits(8'h5A, 8'h5A, 3, -1, 0, cyc);
        in_valid = 1'b0; in_first = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_count", int'(match_count), 0);
        tick();
        rst = 1'b0;
        tick();
        send_word(8'hFF, 8'hFE, -1, 0, cyc);
        wait_result(n);
        chk_result("after_reset", 0, 1, 0, 1, 7);
        tick();

        // Random traffic against the model.
        words = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_first  = ($urandom % 12) == 0;
            x_bit     = 1'($urandom);
            y_bit     = ($urandom % 3 == 0) ? ~x_bit : x_bit;
            out_ready = ($urandom % 2) == 0;
            if (out_valid && out_ready) words++;
            tick();
        end
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("random_drained", int'(out_valid), 0);
        chk("random_words_seen", int'(words > 3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_pair_comparator.md
Name: serial_pair_comparator

Overview:
- Bit-serial counterpart to the team's parallel bit-pair match logic.
- Accepts an operand pair (X, Y) one bit-pair per clock, MSB first, under a valid/ready handshake.
- After WIDTH bits, presents equal/greater/less flags, the any-bit-match flag (OR over all positions of x_i XNOR y_i) and a count of matching positions. The result is held until the consumer accepts it.
- Sits between the serial pattern source and the result checker in the project datapath.

Parameters:
- WIDTH, 8: bits per operand; legal range 1..255.
- CW, $clog2(WIDTH+1): width of the bit counter and match_count (localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  bit-pair present on x_bit/y_bit.
- in_first  in  1  qualifies the MSB of a new operand pair.
- x_bit  in  1  current bit of X.
- y_bit  in  1  current bit of Y.
- in_ready  out  1  block can accept a bit-pair.
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer accepts result.
- eq  out  1  X == Y.
- gt  out  1  X > Y (unsigned).
- lt  out  1  X < Y (unsigned).
- any_match  out  1  at least one bit position with x_i == y_i.
- match_count  out  CW  number of positions with x_i == y_i (0..WIDTH).

Behaviour:
- Reset (async assert, sync-released by upstream): state=IDLE, in_ready=0 while rst is high, then 1. out_valid=0; eq=gt=lt=any_match=0; match_count=0; bit counter=0.
- Accept event: in_valid & in_ready at a rising clk edge.
- States:
  - IDLE: in_ready=1. An accept with in_first=1 loads bit 0. An accept with in_first=0 is discarded (no state change).
  - SHIFT: in_ready=1. Each accept consumes one bit.
  - DONE: in_ready=0, out_valid=1, result registers frozen.
- Per-bit update (registered, on accept):
  - m = ~(x_bit ^ y_bit).
  - match_count += m; any_match |= m.
  - If still undecided (eq_run=1) and x_bit != y_bit: gt = x_bit, lt = y_bit, eq_run = 0.
  - On bit 0, all accumulators are initialised from that bit alone; prior contents are ignored.
- Transitions:
  - IDLE -> SHIFT on first accept when WIDTH > 1.
  - SHIFT -> DONE on the accept of bit WIDTH-1.
  - IDLE -> DONE directly when WIDTH = 1.
  - DONE -> IDLE on out_valid & out_ready.
- Latency:
  - out_valid rises in the cycle after the edge that accepted the last bit. The last bit's contribution is visible in the result fields in that same cycle.
  - Minimum WIDTH+1 cycles from first accept to result. in_valid gaps stall the counter without loss.
- eq is registered as eq_run at the DONE transition. Exactly one of eq/gt/lt is 1 while out_valid=1.
- Field values while out_valid=0 are don't-care to the consumer but must not be X after reset.
- Restart: in SHIFT, an accept with in_first=1 aborts the partial word and reinitialises from this bit as bit 0. No result is emitted for the aborted word.
- Back-to-back: in_ready is 0 in DONE, so a new word's MSB is accepted no earlier than the cycle after the result handshake. There is no bypass; in the handshake cycle itself the MSB is not taken.
- out_valid stays high and fields stay stable until out_ready. out_ready while out_valid=0 is ignored.
- Async reset mid-word or in DONE: immediate return to reset values; the partial word is discarded.
- Counter never exceeds WIDTH-1 in SHIFT. match_count saturates naturally at WIDTH; no wrap is possible.

Decomposition:
- Shared package proj1_pkg:
  - state enum (IDLE, SHIFT, DONE), 2-bit encoding.
  - cmp result typedef {eq, gt, lt, any_match}.
- One natural sub-module: bit_pair_cell. It is combinational and, from x_bit, y_bit and the eq_run state, produces m, diff and the gt/lt decision for the current bit.
- The FSM, counter and accumulators live in the top.

Test Plan:
- Equal operands: WIDTH=8, X=Y=8'hA5, continuous valid, out_ready=1 -> out_valid exactly one cycle, 9 cycles after first accept; eq=1, gt=lt=0, any_match=1, match_count=8.
- Complement operands: X=8'h0F, Y=8'hF0 -> gt=0, lt=1, eq=0, any_match=0, match_count=0.
- MSB decides despite later bits: X=8'h80, Y=8'h7F, in_valid deasserted for 3 cycles after bit 4 -> gt=1, match_count=0, result delayed exactly 3 cycles.
- Abort/restart: in_first reasserted on bit 5 of X=8'h12, followed by a full X=8'h3C, Y=8'h3D -> a single result: lt=1, match_count=7.
- Backpressure: out_ready=0 for 5 cycles with X=Y=8'h00 -> fields stable, in_ready=0, in_first pulses dropped. After out_ready=1, in_ready=1 from the next cycle.
- Reset mid-word: rst pulsed during bit 3 -> out_valid=0, match_count=0. The next word X=8'hFF, Y=8'hFE gives gt=1, match_count=7.
